reset_sequencer: RTL
====================

# reset_sequencer

Parametrised single-clock reset sequencer: conditions a raw board reset and a PLL lock indication, then releases `NUM_CH` active-low reset outputs one at a time with a programmable stagger. It sits directly behind the PLL in the clock/reset area and drives per-subsystem resets. Loss of PLL lock and software reset are handled at run time without a board reset, which the previous generation did not support. All outputs are in the `clk` domain; downstream clock-domain crossing is the consumer's job.

## Interface
- `NUM_CH`, 3: number of staged reset outputs, ≥1.
- `DEBOUNCE_LEN`, 16: consecutive high samples of ext reset required, ≥1.
- `STAGE_DLY`, 64: cycles between successive channel releases, ≥1.
- `CNT_W`, $clog2(max(DEBOUNCE_LEN,STAGE_DLY))+1: counter width (derived, not overridden).

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous active-low reset, one clock.
- `ext_reset_n`  in  1  raw board reset, asynchronous, may bounce.
- `pll_lock`  in  1  PLL lock, asynchronous.
- `sw_reset`  in  1  single-cycle software reset request, `clk` domain.
- `clr_lock_lost`  in  1  clears sticky `lock_lost`.
- `rst_out_n`  out  NUM_CH  staged resets; bit 0 released first.
- `ready`  out  1  all channels released.
- `lock_lost`  out  1  sticky: lock dropped after entering RELEASE.
- `stage`  out  $clog2(NUM_CH)+1  index of next channel to release.

## Operation
- `ext_reset_n` and `pll_lock` each pass through a 2-flop synchroniser; both flops reset to 0. Synchronised values are `ext_s` and `lock_s`.
- Sync reset (`reset_n`=0): state=DEBOUNCE, cnt=0, stage=0, `rst_out_n`=0, `ready`=0, `lock_lost`=0, synchroniser flops=0.
- States:
  - **DEBOUNCE**: if `ext_s`=0, cnt=0. Otherwise cnt++. When `ext_s`=1 and cnt==DEBOUNCE_LEN-1, go to WAIT_LOCK with cnt=0.
  - **WAIT_LOCK**: when `lock_s`=1, go to RELEASE with cnt=0, stage=0.
  - **RELEASE**: cnt++. When cnt==STAGE_DLY-1: set `rst_out_n[stage]`=1, stage++, cnt=0. Releasing channel NUM_CH-1 goes to RUN and sets `ready`=1 on the same edge.
  - **HOLD**: all outputs asserted; cnt++. At cnt==STAGE_DLY-1, go to RELEASE with cnt=0, stage=0.
  - **RUN**: steady state.
- Abort rules, evaluated every cycle in every state except DEBOUNCE, in priority order:
  1. `ext_s`=0 → DEBOUNCE.
  2. `lock_s`=0 while in RELEASE, RUN or HOLD → WAIT_LOCK, and set `lock_lost`=1.
  3. `sw_reset`=1 while in RELEASE or RUN → HOLD.
- Any abort, on the same edge: `rst_out_n`=all 0, `ready`=0, cnt=0, stage=0.
- `sw_reset` in DEBOUNCE or WAIT_LOCK is ignored.
- `lock_lost`: set has priority over `clr_lock_lost` when both occur in the same cycle; cleared only by `clr_lock_lost` or `reset_n`.
- Release is monotonic: bits only go 0→1 in ascending order. Assertion is always all bits at once.

## Timing
- Let E0 be the first edge with `reset_n`=1, with `ext_reset_n` and `pll_lock` already stable high.
  - `ext_s`/`lock_s` become 1 after E1.
  - DEBOUNCE exits at E(1+DEBOUNCE_LEN).
  - RELEASE is entered at E(2+DEBOUNCE_LEN).
  - Channel k deasserts at E(2+DEBOUNCE_LEN+(k+1)·STAGE_DLY).
  - `ready` rises with channel NUM_CH-1.
- Abort latency:
  - External input falls at edge n → outputs asserted after edge n+3 (2 sync + 1 registered).
  - `sw_reset` → outputs asserted after the next edge.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package `reset_seq_pkg`: state enum (DEBOUNCE, WAIT_LOCK, RELEASE, HOLD, RUN) and a `max` helper function for `CNT_W`.
- Sub-module `sync_2ff`: 2-flop synchroniser with sync active-low reset and parametrised reset value, instantiated for `ext_reset_n` and `pll_lock`.
- Elaboration-time checks on the parameter lower bounds.

## Test plan
All scenarios use NUM_CH=3, DEBOUNCE_LEN=4, STAGE_DLY=8.
- **Power-up**: inputs high, `reset_n` high at E0 → `rst_out_n` = 001 at E14, 011 at E22, 111 with `ready`=1 at E30; `stage` steps 0,1,2,3.
- **Bounce**: `ext_reset_n` toggles low for 1 cycle every 3 cycles → state stays in DEBOUNCE, `rst_out_n`=000 throughout; after 4 steady high `ext_s` samples, the sequence proceeds as in power-up.
- **Lock loss in RUN**: drop `pll_lock` → `rst_out_n`=000, `ready`=0, `lock_lost`=1 three edges later; restore lock → re-release with 8-cycle stagger; `lock_lost` stays 1 until `clr_lock_lost` pulses.
- **sw_reset in RELEASE** after channel 0 is out → next edge all 0, HOLD for 8 cycles, then channel 0 releases 8 cycles later; `lock_lost` stays 0.
- **Simultaneous**: `ext_reset_n` low and `sw_reset` in the same cycle in RUN → state ends in DEBOUNCE, not HOLD.
- **Mid-sequence `reset_n` pulse**: outputs 000, `lock_lost` 0; restart timing identical to power-up.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Holds the sequencer state encoding and the helper used to size its counter.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        DEBOUNCE  = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// Both flops load RST_VAL while reset_n is low.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Conditions board reset and PLL lock, then releases NUM_CH active-low resets
// one at a time with a fixed stagger; handles lock loss and software reset at run time.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int DEBOUNCE_LEN = 16,
    parameter int STAGE_DLY    = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ext_reset_n,
    input  logic                      pll_lock,
    input  logic                      sw_reset,
    input  logic                      clr_lock_lost,
    output logic [NUM_CH-1:0]         rst_out_n,
    output logic                      ready,
    output logic                      lock_lost,
    output logic [$clog2(NUM_CH):0]   stage
);

    localparam int CNT_W = $clog2(max(DEBOUNCE_LEN, STAGE_DLY)) + 1;
    localparam int STG_W = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_LEN - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0] CH_LAST  = STG_W'(NUM_CH - 1);

    generate
        if (NUM_CH < 1) begin : g_bad_num_ch
            $error("reset_sequencer: NUM_CH must be >= 1");
        end
        if (DEBOUNCE_LEN < 1) begin : g_bad_debounce
            $error("reset_sequencer: DEBOUNCE_LEN must be >= 1");
        end
        if (STAGE_DLY < 1) begin : g_bad_stage_dly
            $error("reset_sequencer: STAGE_DLY must be >= 1");
        end
    endgenerate

    logic ext_s;
    logic lock_s;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_ext (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ext_reset_n),
        .q       (ext_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_lock (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [STG_W-1:0]   stage_nx;
    logic [NUM_CH-1:0]  rst_nx;
    logic               ready_nx;
    logic               lost_set;
    logic               abort;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stage_nx = stage;
        rst_nx   = rst_out_n;
        ready_nx = ready;
        lost_set = 1'b0;
        abort    = 1'b0;

        // Aborts are ranked: board reset, then lock loss, then software reset.
        if (state != DEBOUNCE) begin
            if (!ext_s) begin
                state_nx = DEBOUNCE;
                abort    = 1'b1;
            end else if (!lock_s && state != WAIT_LOCK) begin
                state_nx = WAIT_LOCK;
                lost_set = 1'b1;
                abort    = 1'b1;
            end else if (sw_reset && (state == RELEASE || state == RUN)) begin
                state_nx = HOLD;
                abort    = 1'b1;
            end
        end

        if (abort) begin
            cnt_nx   = '0;
            stage_nx = '0;
            rst_nx   = '0;
            ready_nx = 1'b0;
        end else begin
            case (state)
                DEBOUNCE: begin
                    if (!ext_s) begin
                        cnt_nx = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nx = WAIT_LOCK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = RELEASE;
                        cnt_nx   = '0;
                        stage_nx = '0;
                    end
                end
                RELEASE: begin
                    if (cnt == STG_LAST) begin
                        cnt_nx   = '0;
                        rst_nx   = rst_out_n | (NUM_CH'(1) << stage);
                        stage_nx = stage + 1'b1;
                        if (stage == CH_LAST) begin
                            state_nx = RUN;
                            ready_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == STG_LAST) begin
                        state_nx = RELEASE;
                        cnt_nx   = '0;
                        stage_nx = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_nx = DEBOUNCE;
                    cnt_nx   = '0;
                    stage_nx = '0;
                    rst_nx   = '0;
                    ready_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= DEBOUNCE;
            cnt       <= '0;
            stage     <= '0;
            rst_out_n <= '0;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            stage     <= stage_nx;
            rst_out_n <= rst_nx;
            ready     <= ready_nx;
            // A new lock loss wins over a clear in the same cycle.
            if (lost_set) begin
                lock_lost <= 1'b1;
            end else if (clr_lock_lost) begin
                lock_lost <= 1'b0;
            end
        end
    end

endmodule
